// File: rtl/sign_apply_serial.sv
// ---------------------------------------------------------------------------
// sign_apply_serial
//
// Purpose:
//   Bit-serial sign applier. It takes an N-bit unsigned magnitude and a sign
//   bit, and produces the N-bit two's-complement value one bit per clock,
//   LSB first. This is the inverse of an ABS unit: it rebuilds a signed result
//   after magnitude-only arithmetic. Negation uses the "copy bits up to and
//   including the first 1, then invert the rest" rule, so no adder is needed.
//
// Ports:
//   Clk      in   1  rising-edge clock
//   Rst      in   1  synchronous, active-high reset
//   Start    in   1  conversion request, accepted only in IDLE
//   Mag      in   N  unsigned magnitude, captured on the accepting edge
//   Sign     in   1  1 = negative result, captured with Mag
//   Busy     out  1  high from the accepting edge through the Done cycle
//   Done     out  1  one-cycle pulse; Y/Overflow valid from this cycle on
//   Y        out  N  two's-complement result, held until the next Done
//   Overflow out  1  result does not fit N-bit signed (Y is still modulo 2^N)
// ---------------------------------------------------------------------------
module sign_apply_serial #(
    parameter int N = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [N-1:0] Mag,
    input  logic         Sign,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Y,
    output logic         Overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   shift_reg;
    logic [N-1:0]   result_reg;
    logic [CW-1:0]  bit_cnt;
    logic           sign_q;
    logic           seen_one;
    logic           ovf_q;

    logic           cur_bit;
    logic           out_bit;
    logic           ovf_next;

    // Serial negation: bits pass through unchanged until the first 1 has gone
    // by, after which every remaining bit is inverted. A positive sign simply
    // copies the magnitude through.
    always_comb begin
        cur_bit = shift_reg[0];
        out_bit = cur_bit ^ (sign_q & seen_one);
    end

    // Overflow depends only on the captured operands, so it is decided once at
    // the accepting edge. The single negative value with no positive twin,
    // -2^(N-1), is representable and therefore not an overflow.
    always_comb begin
        if (Sign) begin
            ovf_next = Mag[N-1] & (|Mag[N-2:0]);
        end else begin
            ovf_next = Mag[N-1];
        end
    end

    // Control FSM and datapath. Outputs are registered one edge behind the
    // state: the DONE state publishes Y/Overflow and raises Done on its exit
    // edge, so Done appears N+1 cycles after acceptance and Busy covers that
    // cycle too. Acceptance is gated on the state, which lets a new Start land
    // on the first edge after Done while Busy is still visibly high.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            result_reg <= '0;
            bit_cnt    <= '0;
            sign_q     <= 1'b0;
            seen_one   <= 1'b0;
            ovf_q      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Y          <= '0;
            Overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    Busy <= Start;
                    if (Start) begin
                        shift_reg  <= Mag;
                        result_reg <= '0;
                        sign_q     <= Sign;
                        seen_one   <= 1'b0;
                        bit_cnt    <= '0;
                        ovf_q      <= ovf_next;
                        state      <= SHIFT;
                    end
                end

                SHIFT: begin
                    Done       <= 1'b0;
                    Busy       <= 1'b1;
                    seen_one   <= seen_one | cur_bit;
                    shift_reg  <= shift_reg >> 1;
                    result_reg <= {out_bit, result_reg[N-1:1]};
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(N - 1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    Done     <= 1'b1;
                    Busy     <= 1'b1;
                    Y        <= result_reg;
                    Overflow <= ovf_q;
                    state    <= IDLE;
                end

                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
